obi_amo_resolver: RTL and testbench

- Sits between an OBI manager that issues atomics (atop) and an OBI subordinate without atomic support, such as an SRAM or a peripheral bridge.
- Splits each AMO into read-modify-write subordinate transactions, tracks an LR/SC reservation, and forwards plain reads/writes unchanged.
- Single outstanding transaction; manager R channel has no rready.

---
 rtl/obi_pkg.sv | 46 ++++
 rtl/obi_amo_alu.sv | 39 +++
 rtl/obi_amo_resolver.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_obi_amo_resolver.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI atomic definitions for the AMO resolver.
// Holds the atop encoding, the resolver state type and an atop validity helper.
package obi_pkg;

    // Raw 6-bit atop field as carried on the bus
    typedef logic [5:0] atop_t;

    // Recognised atop encodings: bit 5 marks an atomic, bits 4:0 carry the RISC-V funct5
    typedef enum logic [5:0] {
        AMONONE = 6'h00,
        AMOADD  = 6'h20,
        AMOSWAP = 6'h21,
        AMOLR   = 6'h22,
        AMOSC   = 6'h23,
        AMOXOR  = 6'h24,
        AMOOR   = 6'h28,
        AMOAND  = 6'h2C,
        AMOMIN  = 6'h30,
        AMOMAX  = 6'h34,
        AMOMINU = 6'h38,
        AMOMAXU = 6'h3C
    } obi_atop_e;

    // Resolver sequencing states
    typedef enum logic [2:0] {
        IDLE,
        PASS,
        RD,
        RD_W,
        WR,
        WR_W,
        RESP
    } amo_state_e;

    // Returns 1 when the atop value is one of the obi_atop_e members
    function automatic logic is_valid_atop(input atop_t atop);
        logic valid;
        case (atop)
            AMONONE, AMOADD, AMOSWAP, AMOLR, AMOSC, AMOXOR,
            AMOOR, AMOAND, AMOMIN, AMOMAX, AMOMINU, AMOMAXU: valid = 1'b1;
            default: valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/obi_amo_alu.sv
// obi_amo_alu: combinational AMO datapath computing the value written back to
// memory from the old memory word and the manager-supplied operand.
module obi_amo_alu
    import obi_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [5:0]           atop_i,
    input  logic [DataWidth-1:0] old_i,
    input  logic [DataWidth-1:0] operand_i,
    output logic [DataWidth-1:0] new_o
);

    logic old_lt_signed;
    logic old_lt_unsigned;

    // Comparisons shared by the min/max variants
    always_comb begin
        old_lt_signed   = $signed(old_i) < $signed(operand_i);
        old_lt_unsigned = old_i < operand_i;
    end

    // Select the write-back value; SWAP and SC store the operand unchanged
    always_comb begin
        new_o = operand_i;
        case (atop_i)
            AMOADD:  new_o = old_i + operand_i;
            AMOXOR:  new_o = old_i ^ operand_i;
            AMOAND:  new_o = old_i & operand_i;
            AMOOR:   new_o = old_i | operand_i;
            AMOMIN:  new_o = old_lt_signed   ? old_i : operand_i;
            AMOMAX:  new_o = old_lt_signed   ? operand_i : old_i;
            AMOMINU: new_o = old_lt_unsigned ? old_i : operand_i;
            AMOMAXU: new_o = old_lt_unsigned ? operand_i : old_i;
            default: new_o = operand_i;
        endcase
    end

endmodule

// File: rtl/obi_amo_resolver.sv
// obi_amo_resolver: turns OBI atomics into read-modify-write sequences on a
// subordinate without atomic support; plain reads/writes pass straight through.
// One transaction outstanding at a time.
// Build option: define OBI_AMO_LRSC_EN to keep an LR/SC reservation; without it
// LR acts as a plain read and SC is rejected with an error.
module obi_amo_resolver
    import obi_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mgr_req_i,
    output logic                   mgr_gnt_o,
    input  logic [AddrWidth-1:0]   mgr_addr_i,
    input  logic                   mgr_we_i,
    input  logic [DataWidth/8-1:0] mgr_be_i,
    input  logic [DataWidth-1:0]   mgr_wdata_i,
    input  logic [IdWidth-1:0]     mgr_aid_i,
    input  logic [5:0]             mgr_atop_i,
    output logic                   mgr_rvalid_o,
    output logic [DataWidth-1:0]   mgr_rdata_o,
    output logic [IdWidth-1:0]     mgr_rid_o,
    output logic                   mgr_err_o,
    output logic                   mgr_exokay_o,
    output logic                   sbr_req_o,
    input  logic                   sbr_gnt_i,
    output logic [AddrWidth-1:0]   sbr_addr_o,
    output logic                   sbr_we_o,
    output logic [DataWidth/8-1:0] sbr_be_o,
    output logic [DataWidth-1:0]   sbr_wdata_o,
    output logic [IdWidth-1:0]     sbr_aid_o,
    input  logic                   sbr_rvalid_i,
    input  logic [DataWidth-1:0]   sbr_rdata_i,
    input  logic                   sbr_err_i
);

    localparam int BeWidth = DataWidth / 8;
    localparam logic [DataWidth-1:0] ScFailData = DataWidth'(1);

    if (DataWidth != 32) begin : gen_width_check
        $error("obi_amo_resolver supports only DataWidth == 32");
    end

    amo_state_e             state_q, state_d, cur_state;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [BeWidth-1:0]     be_q, be_d;
    logic [IdWidth-1:0]     aid_q, aid_d;
    atop_t                  atop_q, atop_d;
    logic [DataWidth-1:0]   old_q, old_d;
    logic [DataWidth-1:0]   resp_rdata_q, resp_rdata_d;
    logic                   err_q, err_d;
    logic                   exokay_q, exokay_d;
    logic [DataWidth-1:0]   alu_new;
`ifdef OBI_AMO_LRSC_EN
    logic                   resv_valid_q, resv_valid_d;
    logic [AddrWidth-3:0]   resv_addr_q, resv_addr_d;
`endif

    obi_amo_alu #(
        .DataWidth (DataWidth)
    ) u_alu (
        .atop_i    (atop_q),
        .old_i     (old_q),
        .operand_i (wdata_q),
        .new_o     (alu_new)
    );

    // Reset makes the block behave as IDLE in the very cycle it is asserted
    assign cur_state = rst_i ? IDLE : state_q;

    // Next-state, capture and output decode for the whole resolver
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        aid_d        = aid_q;
        atop_d       = atop_q;
        old_d        = old_q;
        resp_rdata_d = resp_rdata_q;
        err_d        = err_q;
        exokay_d     = exokay_q;
`ifdef OBI_AMO_LRSC_EN
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
`endif

        mgr_gnt_o    = 1'b0;
        mgr_rvalid_o = 1'b0;
        mgr_rdata_o  = resp_rdata_q;
        mgr_rid_o    = aid_q;
        mgr_err_o    = err_q;
        mgr_exokay_o = exokay_q;
        sbr_req_o    = 1'b0;
        sbr_addr_o   = addr_q;
        sbr_we_o     = 1'b0;
        sbr_be_o     = '1;
        sbr_wdata_o  = alu_new;
        sbr_aid_o    = aid_q;

        case (cur_state)
            IDLE: begin
                if (mgr_atop_i == AMONONE) begin
                    sbr_req_o   = mgr_req_i;
                    sbr_addr_o  = mgr_addr_i;
                    sbr_we_o    = mgr_we_i;
                    sbr_be_o    = mgr_be_i;
                    sbr_wdata_o = mgr_wdata_i;
                    sbr_aid_o   = mgr_aid_i;
                    mgr_gnt_o   = sbr_gnt_i;
                    if (mgr_req_i && sbr_gnt_i) begin
                        aid_d   = mgr_aid_i;
                        state_d = PASS;
`ifdef OBI_AMO_LRSC_EN
                        if (mgr_we_i && (mgr_addr_i[AddrWidth-1:2] == resv_addr_q)) begin
                            resv_valid_d = 1'b0;
                        end
`endif
                    end
                end else begin
                    mgr_gnt_o = 1'b1;
                    if (mgr_req_i) begin
                        addr_d       = mgr_addr_i;
                        wdata_d      = mgr_wdata_i;
                        be_d         = mgr_be_i;
                        aid_d        = mgr_aid_i;
                        atop_d       = mgr_atop_i;
                        resp_rdata_d = '0;
                        err_d        = 1'b0;
                        exokay_d     = 1'b0;
                        if ((mgr_addr_i[1:0] != 2'b00) || !is_valid_atop(mgr_atop_i)) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
`ifndef OBI_AMO_LRSC_EN
                        else if (mgr_atop_i == AMOSC) begin
                            err_d        = 1'b1;
                            resp_rdata_d = ScFailData;
                            state_d      = RESP;
                        end
`endif
                        else begin
                            state_d = RD;
                        end
                    end
                end
            end

            PASS: begin
                mgr_rvalid_o = sbr_rvalid_i;
                mgr_rdata_o  = sbr_rdata_i;
                mgr_err_o    = sbr_err_i;
                mgr_exokay_o = 1'b0;
                if (sbr_rvalid_i) begin
                    state_d = IDLE;
                end
            end

            RD: begin
                sbr_req_o = 1'b1;
                if (sbr_gnt_i) begin
                    state_d = RD_W;
                end
            end

            RD_W: begin
                if (sbr_rvalid_i) begin
                    old_d        = sbr_rdata_i;
                    resp_rdata_d = sbr_rdata_i;
`ifdef OBI_AMO_LRSC_EN
                    if (atop_q == AMOSC) begin
                        resv_valid_d = 1'b0;
                    end
`endif
                    if (sbr_err_i) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (atop_q == AMOLR) begin
`ifdef OBI_AMO_LRSC_EN
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q[AddrWidth-1:2];
                        exokay_d     = 1'b1;
`endif
                        state_d = RESP;
                    end
`ifdef OBI_AMO_LRSC_EN
                    else if (atop_q == AMOSC) begin
                        if (resv_valid_q && (resv_addr_q == addr_q[AddrWidth-1:2])) begin
                            resp_rdata_d = '0;
                            exokay_d     = 1'b1;
                            state_d      = WR;
                        end else begin
                            resp_rdata_d = ScFailData;
                            state_d      = RESP;
                        end
                    end
`endif
                    else begin
                        state_d = WR;
                    end
                end
            end

            WR: begin
                sbr_req_o   = 1'b1;
                sbr_we_o    = 1'b1;
                sbr_be_o    = be_q;
                if (sbr_gnt_i) begin
                    state_d = WR_W;
`ifdef OBI_AMO_LRSC_EN
                    if (resv_addr_q == addr_q[AddrWidth-1:2]) begin
                        resv_valid_d = 1'b0;
                    end
`endif
                end
            end

            WR_W: begin
                if (sbr_rvalid_i) begin
                    err_d = err_q | sbr_err_i;
                    if (sbr_err_i) begin
                        exokay_d = 1'b0;
                    end
                    state_d = RESP;
                end
            end

            RESP: begin
                mgr_rvalid_o = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst_i) begin
            sbr_req_o    = 1'b0;
            mgr_rvalid_o = 1'b0;
        end
    end

    // State, capture and reservation registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            aid_q        <= '0;
            atop_q       <= '0;
            old_q        <= '0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
            exokay_q     <= 1'b0;
`ifdef OBI_AMO_LRSC_EN
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            aid_q        <= aid_d;
            atop_q       <= atop_d;
            old_q        <= old_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
            exokay_q     <= exokay_d;
`ifdef OBI_AMO_LRSC_EN
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // A subordinate response is only legal while a response is awaited
    property p_no_stray_rvalid;
        @(posedge clk_i) disable iff (rst_i)
            sbr_rvalid_i |-> (state_q inside {PASS, RD_W, WR_W});
    endproperty
    a_no_stray_rvalid: assert property (p_no_stray_rvalid)
        else $error("obi_amo_resolver: unexpected sbr_rvalid_i");
`endif

endmodule

// File: tb/tb_obi_amo_resolver.sv
// tb_obi_amo_resolver: directed vector bench for obi_amo_resolver with a small
// zero-wait memory model (grant controllable) as the subordinate.
module tb_obi_amo_resolver;
    import obi_pkg::*;

    logic        clk;
    logic        rst;
    logic        mgr_req;
    logic        mgr_gnt;
    logic [31:0] mgr_addr;
    logic        mgr_we;
    logic [3:0]  mgr_be;
    logic [31:0] mgr_wdata;
    logic [0:0]  mgr_aid;
    logic [5:0]  mgr_atop;
    logic        mgr_rvalid;
    logic [31:0] mgr_rdata;
    logic [0:0]  mgr_rid;
    logic        mgr_err;
    logic        mgr_exokay;
    logic        sbr_req;
    logic        sbr_gnt_en;
    logic [31:0] sbr_addr;
    logic        sbr_we;
    logic [3:0]  sbr_be;
    logic [31:0] sbr_wdata;
    logic [0:0]  sbr_aid;
    logic        sbr_rvalid;
    logic [31:0] sbr_rdata;
    logic        sbr_err;

    int checks;
    int failures;
    int req_cnt;
    int wr_cnt;

    logic [31:0] mem [0:255];

    localparam logic [31:0] ErrAddr = 32'h0000_03F0;

    obi_amo_resolver dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mgr_req_i    (mgr_req),
        .mgr_gnt_o    (mgr_gnt),
        .mgr_addr_i   (mgr_addr),
        .mgr_we_i     (mgr_we),
        .mgr_be_i     (mgr_be),
        .mgr_wdata_i  (mgr_wdata),
        .mgr_aid_i    (mgr_aid),
        .mgr_atop_i   (mgr_atop),
        .mgr_rvalid_o (mgr_rvalid),
        .mgr_rdata_o  (mgr_rdata),
        .mgr_rid_o    (mgr_rid),
        .mgr_err_o    (mgr_err),
        .mgr_exokay_o (mgr_exokay),
        .sbr_req_o    (sbr_req),
        .sbr_gnt_i    (sbr_gnt_en),
        .sbr_addr_o   (sbr_addr),
        .sbr_we_o     (sbr_we),
        .sbr_be_o     (sbr_be),
        .sbr_wdata_o  (sbr_wdata),
        .sbr_aid_o    (sbr_aid),
        .sbr_rvalid_i (sbr_rvalid),
        .sbr_rdata_i  (sbr_rdata),
        .sbr_err_i    (sbr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subordinate memory model: answers every granted request in the next cycle
    always @(posedge clk) begin
        if (rst) begin
            sbr_rvalid <= 1'b0;
            sbr_rdata  <= '0;
            sbr_err    <= 1'b0;
        end else begin
            sbr_rvalid <= sbr_req && sbr_gnt_en;
            if (sbr_req && sbr_gnt_en) begin
                req_cnt <= req_cnt + 1;
                if (sbr_addr == ErrAddr) begin
                    sbr_err   <= 1'b1;
                    sbr_rdata <= 32'hBAD0_BAD0;
                end else if (sbr_we) begin
                    sbr_err   <= 1'b0;
                    sbr_rdata <= '0;
                    wr_cnt    <= wr_cnt + 1;
                    for (int b = 0; b < 4; b++) begin
                        if (sbr_be[b]) mem[sbr_addr[9:2]][8*b +: 8] <= sbr_wdata[8*b +: 8];
                    end
                end else begin
                    sbr_err   <= 1'b0;
                    sbr_rdata <= mem[sbr_addr[9:2]];
                end
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [5:0]  atop;
        logic        aid;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
        logic        exokay;
        int          lat;
        int          reqs;
        int          writes;
        logic        chk_mem;
        logic [31:0] mem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] addr, logic we, logic [31:0] wdata, logic [5:0] atop,
                                logic aid, logic chk_rdata, logic [31:0] rdata, logic err,
                                logic exokay, int lat, int reqs, int writes, logic chk_mem,
                                logic [31:0] memv);
        vec_t v;
        v.addr = addr; v.we = we; v.wdata = wdata; v.atop = atop; v.aid = aid;
        v.chk_rdata = chk_rdata; v.rdata = rdata; v.err = err; v.exokay = exokay;
        v.lat = lat; v.reqs = reqs; v.writes = writes; v.chk_mem = chk_mem; v.mem = memv;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        mgr_req   = 1'b0;
        mgr_we    = 1'b0;
        mgr_atop  = AMONONE;
        mgr_wdata = '0;
    endtask

    task automatic apply_stimulus(input int idx, input vec_t v);
        int rq0, wr0, lat, cyc;
        rq0 = req_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        mgr_req   = 1'b1;
        mgr_addr  = v.addr;
        mgr_we    = v.we;
        mgr_be    = 4'hF;
        mgr_wdata = v.wdata;
        mgr_aid   = v.aid;
        mgr_atop  = v.atop;
        #1;
        cyc = 0;
        while (!mgr_gnt && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!mgr_gnt) begin
            check_output($sformatf("vec%0d grant_timeout", idx), 32'd0, 32'd1);
            drive_idle();
            return;
        end
        @(posedge clk);
        #1;
        drive_idle();
        lat = 1;
        cyc = 0;
        @(negedge clk);
        while (!mgr_rvalid && cyc < 20) begin
            @(negedge clk);
            lat++;
            cyc++;
        end
        if (!mgr_rvalid) begin
            check_output($sformatf("vec%0d rvalid_timeout", idx), 32'd0, 32'd1);
            return;
        end
        if (v.chk_rdata) check_output($sformatf("vec%0d rdata", idx), mgr_rdata, v.rdata);
        check_output($sformatf("vec%0d err", idx), 32'(mgr_err), 32'(v.err));
        check_output($sformatf("vec%0d exokay", idx), 32'(mgr_exokay), 32'(v.exokay));
        check_output($sformatf("vec%0d rid", idx), 32'(mgr_rid), 32'(v.aid));
        if (v.lat != 0) check_output($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
        @(negedge clk);
        check_output($sformatf("vec%0d rvalid_one_cycle", idx), 32'(mgr_rvalid), 32'd0);
        check_output($sformatf("vec%0d sbr_reqs", idx), 32'(req_cnt - rq0), 32'(v.reqs));
        check_output($sformatf("vec%0d sbr_writes", idx), 32'(wr_cnt - wr0), 32'(v.writes));
        if (v.chk_mem) check_output($sformatf("vec%0d mem", idx), mem[v.addr[9:2]], v.mem);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc, wr0;
        checks     = 0;
        failures   = 0;
        req_cnt    = 0;
        wr_cnt     = 0;
        sbr_gnt_en = 1'b1;
        mgr_addr   = '0;
        mgr_be     = 4'hF;
        mgr_aid    = '0;
        drive_idle();

        // Expected results computed by hand for each directed vector
        vecs.push_back(mk(32'h100, 1, 32'hDEADBEEF, AMONONE, 1, 0, 0, 0, 0, 1, 1, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk(32'h100, 0, 32'h0,        AMONONE, 1, 1, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h104, 1, 32'hFFFFFFFF, AMONONE, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'hFFFFFFFF));
        vecs.push_back(mk(32'h104, 0, 32'h1,        AMOADD,  1, 1, 32'hFFFFFFFF, 0, 0, 5, 2, 1, 1, 32'h0));
        vecs.push_back(mk(32'h108, 1, 32'h80000000, AMONONE, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h80000000));
        vecs.push_back(mk(32'h108, 0, 32'h5,        AMOMIN,  0, 1, 32'h80000000, 0, 0, 5, 2, 1, 1, 32'h80000000));
        vecs.push_back(mk(32'h108, 0, 32'h5,        AMOMINU, 1, 1, 32'h80000000, 0, 0, 5, 2, 1, 1, 32'h5));
        vecs.push_back(mk(32'h108, 0, 32'hFFFFFFFF, AMOMAX,  0, 1, 32'h5, 0, 0, 5, 2, 1, 1, 32'h5));
        vecs.push_back(mk(32'h108, 0, 32'hFFFFFFFF, AMOMAXU, 1, 1, 32'h5, 0, 0, 5, 2, 1, 1, 32'hFFFFFFFF));
        vecs.push_back(mk(32'h108, 0, 32'h0F0F0F0F, AMOXOR,  0, 1, 32'hFFFFFFFF, 0, 0, 5, 2, 1, 1, 32'hF0F0F0F0));
        vecs.push_back(mk(32'h108, 0, 32'hFF00FF00, AMOAND,  1, 1, 32'hF0F0F0F0, 0, 0, 5, 2, 1, 1, 32'hF000F000));
        vecs.push_back(mk(32'h108, 0, 32'h0000000F, AMOOR,   0, 1, 32'hF000F000, 0, 0, 5, 2, 1, 1, 32'hF000F00F));
        vecs.push_back(mk(32'h108, 0, 32'h12345678, AMOSWAP, 1, 1, 32'hF000F00F, 0, 0, 5, 2, 1, 1, 32'h12345678));
        vecs.push_back(mk(32'h102, 0, 32'h55,       AMOSWAP, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(32'h108, 0, 32'h55,       6'h3F,   1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(ErrAddr, 0, 32'h1,        AMOOR,   0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(ErrAddr, 0, 32'h0,        AMONONE, 1, 1, 32'hBAD0BAD0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h200, 1, 32'h0,        AMONONE, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h0));
`ifdef OBI_AMO_LRSC_EN
        vecs.push_back(mk(32'h200, 0, 32'h0,  AMOLR,   1, 1, 32'h0,  0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h200, 0, 32'hAB, AMOSC,   0, 1, 32'h0,  0, 1, 5, 2, 1, 1, 32'hAB));
        vecs.push_back(mk(32'h200, 0, 32'h0,  AMOLR,   1, 1, 32'hAB, 0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h200, 1, 32'h11, AMONONE, 0, 0, 0,      0, 0, 1, 1, 1, 1, 32'h11));
        vecs.push_back(mk(32'h200, 0, 32'h22, AMOSC,   1, 1, 32'h1,  0, 0, 3, 1, 0, 1, 32'h11));
        vecs.push_back(mk(32'h200, 0, 32'h0,  AMOLR,   0, 1, 32'h11, 0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(32'h200, 0, 32'h1,  AMOADD,  1, 1, 32'h11, 0, 0, 5, 2, 1, 1, 32'h12));
        vecs.push_back(mk(32'h200, 0, 32'h33, AMOSC,   0, 1, 32'h1,  0, 0, 3, 1, 0, 1, 32'h12));
`else
        vecs.push_back(mk(32'h200, 0, 32'h0,  AMOLR,   1, 1, 32'h0,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'h200, 0, 32'hAB, AMOSC,   0, 1, 32'h1,  1, 0, 0, 0, 0, 1, 32'h0));
`endif

        // Reset: outputs quiet even with a plain request pending
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mgr_req  = 1'b1;
        mgr_addr = 32'h100;
        #1;
        check_output("reset sbr_req", 32'(sbr_req), 32'd0);
        check_output("reset rvalid", 32'(mgr_rvalid), 32'd0);
        check_output("reset gnt_idle", 32'(mgr_gnt), 32'd1);
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("post_reset rvalid", 32'(mgr_rvalid), 32'd0);
        check_output("post_reset sbr_req", 32'(sbr_req), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Grant back-pressure and reset while the AMO write is pending
        sbr_gnt_en = 1'b0;
        @(negedge clk);
        mgr_req  = 1'b1;
        mgr_addr = 32'h104;
        mgr_atop = AMONONE;
        #1;
        check_output("plain gnt_follows_sbr", 32'(mgr_gnt), 32'd0);
        check_output("plain sbr_req_pass", 32'(sbr_req), 32'd1);
        mgr_atop  = AMOADD;
        mgr_wdata = 32'h7;
        #1;
        check_output("amo gnt_same_cycle", 32'(mgr_gnt), 32'd1);
        check_output("amo no_passthrough_req", 32'(sbr_req), 32'd0);
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output($sformatf("rd_hold%0d req", k), 32'(sbr_req), 32'd1);
            check_output($sformatf("rd_hold%0d we", k), 32'(sbr_we), 32'd0);
            check_output($sformatf("rd_hold%0d addr", k), sbr_addr, 32'h104);
        end
        sbr_gnt_en = 1'b1;
        @(posedge clk);
        #1;
        sbr_gnt_en = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!(sbr_req && sbr_we) && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_output("wr_reached", 32'(sbr_req && sbr_we), 32'd1);
        check_output("wr_data", sbr_wdata, 32'h7);
        check_output("wr_be", 32'(sbr_be), 32'hF);
        rst = 1'b1;
        #1;
        check_output("wr_reset sbr_req", 32'(sbr_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbr_gnt_en = 1'b1;
        @(negedge clk);
        check_output("after_reset sbr_req", 32'(sbr_req), 32'd0);
        check_output("after_reset rvalid", 32'(mgr_rvalid), 32'd0);
        check_output("after_reset no_write", 32'(wr_cnt - wr0), 32'd0);
        apply_stimulus(100, mk(32'h104, 0, 32'h0, AMONONE, 1, 1, 32'h0, 0, 0, 1, 1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
